// File: rtl/flash_score_sequencer.sv
// Score save/load sequencer: splits each operation into single-byte flash cycles over a request/done handshake.
// Optional post-save readback verify is enabled by defining FLASH_SEQ_VERIFY_EN.
module flash_score_sequencer #(
  parameter int          N_BYTES    = 4,
  parameter logic [7:0]  BASE_ADDR  = 8'h10,
  parameter logic [15:0] POLL_LIMIT = 16'd50000
) (
  input  logic                 clk_f,
  input  logic                 rst,
  input  logic                 save_req,
  input  logic                 load_req,
  input  logic [8*N_BYTES-1:0] score_in,
  output logic [8*N_BYTES-1:0] score_out,
  output logic                 busy,
  output logic                 ok,
  output logic                 err,
  output logic [7:0]           fl_addr,
  output logic [7:0]           fl_wdata,
  output logic                 fl_dir,
  output logic                 fl_do,
  input  logic [7:0]           fl_rdata,
  input  logic                 fl_done
);

  localparam int IW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE, S_CMD, S_DATA, S_POLL, S_CHK, S_ARRAY, L_ARRAY, L_READ, V_READ, ERR, FINISH
  } state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic          pend_reg, pend_next;
  logic [15:0]   poll_reg, poll_next;
  logic          stat_err_reg, stat_err_next;
  logic [7:0]    latch_reg [N_BYTES];
  logic [7:0]    latch_next [N_BYTES];
  logic [7:0]    sout_reg [N_BYTES];
  logic [7:0]    sout_next [N_BYTES];
  logic          busy_reg, busy_next, ok_reg, ok_next, err_reg, err_next;
  logic          fl_do_reg, fl_do_next, fl_dir_reg, fl_dir_next;
  logic [7:0]    fl_addr_reg, fl_addr_next, fl_wdata_reg, fl_wdata_next;

  logic       issue, iss_dir, done;
  logic [7:0] iss_addr, iss_data, byte_addr;

  assign byte_addr = BASE_ADDR + 8'(idx_reg);
  // A completion only counts while our own cycle is outstanding.
  assign done = fl_done && pend_reg;

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    pend_next     = pend_reg;
    poll_next     = poll_reg;
    stat_err_next = stat_err_reg;
    latch_next    = latch_reg;
    sout_next     = sout_reg;
    busy_next     = busy_reg;
    ok_next       = 1'b0;
    err_next      = err_reg;
    fl_do_next    = 1'b0;
    fl_dir_next   = fl_dir_reg;
    fl_addr_next  = fl_addr_reg;
    fl_wdata_next = fl_wdata_reg;
    issue         = 1'b0;
    iss_dir       = 1'b0;
    iss_addr      = byte_addr;
    iss_data      = 8'h00;
    if (done) pend_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (save_req) begin
          for (int k = 0; k < N_BYTES; k++) latch_next[k] = score_in[8*k +: 8];
          idx_next   = '0;
          busy_next  = 1'b1;
          err_next   = 1'b0;
          state_next = S_CMD;
        end else if (load_req) begin
          busy_next  = 1'b1;
          err_next   = 1'b0;
          state_next = L_ARRAY;
        end
      end
      S_CMD: begin
        issue    = !pend_reg;
        iss_data = 8'h40;
        if (done) state_next = S_DATA;
      end
      S_DATA: begin
        issue    = !pend_reg;
        iss_data = latch_reg[idx_reg];
        if (done) begin
          poll_next  = '0;
          state_next = S_POLL;
        end
      end
      S_POLL: begin
        issue   = !pend_reg;
        iss_dir = 1'b1;
        if (done) begin
          poll_next = poll_reg + 16'd1;
          if (fl_rdata[7]) begin
            stat_err_next = fl_rdata[4] | fl_rdata[3];
            state_next    = S_CHK;
          end else if (poll_reg + 16'd1 == POLL_LIMIT) begin
            state_next = ERR;
          end
        end
      end
      S_CHK: begin
        if (stat_err_reg) begin
          issue    = !pend_reg;
          iss_data = 8'h50;
          if (done) state_next = ERR;
        end else if (idx_reg == LAST_IDX) begin
          state_next = S_ARRAY;
        end else begin
          idx_next   = idx_reg + 1'b1;
          state_next = S_CMD;
        end
      end
      S_ARRAY: begin
        issue    = !pend_reg;
        iss_addr = BASE_ADDR;
        iss_data = 8'hFF;
        if (done) begin
`ifdef FLASH_SEQ_VERIFY_EN
          idx_next   = '0;
          state_next = V_READ;
`else
          state_next = FINISH;
`endif
        end
      end
`ifdef FLASH_SEQ_VERIFY_EN
      V_READ: begin
        issue   = !pend_reg;
        iss_dir = 1'b1;
        if (done) begin
          if (fl_rdata != latch_reg[idx_reg]) state_next = ERR;
          else if (idx_reg == LAST_IDX)       state_next = FINISH;
          else                                idx_next   = idx_reg + 1'b1;
        end
      end
`endif
      L_ARRAY: begin
        issue    = !pend_reg;
        iss_addr = BASE_ADDR;
        iss_data = 8'hFF;
        if (done) begin
          idx_next   = '0;
          state_next = L_READ;
        end
      end
      L_READ: begin
        issue   = !pend_reg;
        iss_dir = 1'b1;
        if (done) begin
          sout_next[idx_reg] = fl_rdata;
          if (idx_reg == LAST_IDX) state_next = FINISH;
          else                     idx_next   = idx_reg + 1'b1;
        end
      end
      // Leave the device in read-array mode before reporting the failure.
      ERR: begin
        issue    = !pend_reg;
        iss_data = 8'hFF;
        if (done) begin
          err_next   = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      FINISH: begin
        ok_next    = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (issue) begin
      fl_do_next    = 1'b1;
      pend_next     = 1'b1;
      fl_dir_next   = iss_dir;
      fl_addr_next  = iss_addr;
      fl_wdata_next = iss_data;
    end
  end

  always_ff @(posedge clk_f) begin
    if (rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      pend_reg     <= 1'b0;
      poll_reg     <= '0;
      stat_err_reg <= 1'b0;
      for (int k = 0; k < N_BYTES; k++) begin
        latch_reg[k] <= '0;
        sout_reg[k]  <= '0;
      end
      busy_reg     <= 1'b0;
      ok_reg       <= 1'b0;
      err_reg      <= 1'b0;
      fl_do_reg    <= 1'b0;
      fl_dir_reg   <= 1'b1;
      fl_addr_reg  <= '0;
      fl_wdata_reg <= '0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      pend_reg     <= pend_next;
      poll_reg     <= poll_next;
      stat_err_reg <= stat_err_next;
      latch_reg    <= latch_next;
      sout_reg     <= sout_next;
      busy_reg     <= busy_next;
      ok_reg       <= ok_next;
      err_reg      <= err_next;
      fl_do_reg    <= fl_do_next;
      fl_dir_reg   <= fl_dir_next;
      fl_addr_reg  <= fl_addr_next;
      fl_wdata_reg <= fl_wdata_next;
    end
  end

  assign busy     = busy_reg;
  assign ok       = ok_reg;
  assign err      = err_reg;
  assign fl_do    = fl_do_reg;
  assign fl_dir   = fl_dir_reg;
  assign fl_addr  = fl_addr_reg;
  assign fl_wdata = fl_wdata_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_BYTES; gi++) begin : g_sout
      assign score_out[gi*8 +: 8] = sout_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_flash_score_sequencer.sv
// Scoreboard bench for flash_score_sequencer: a behavioural flash model answers each cycle,
// expected flash cycles and completions are queued by the stimulus and popped by a monitor.
module tb_flash_score_sequencer;
  logic        clk_f, rst, save_req, load_req;
  logic [31:0] score_in, score_out;
  logic        busy, ok, err;
  logic [7:0]  fl_addr, fl_wdata, fl_rdata;
  logic        fl_dir, fl_do, fl_done;

  flash_score_sequencer #(.N_BYTES(4), .BASE_ADDR(8'h10), .POLL_LIMIT(16'd8)) dut (
    .clk_f(clk_f), .rst(rst), .save_req(save_req), .load_req(load_req),
    .score_in(score_in), .score_out(score_out), .busy(busy), .ok(ok), .err(err),
    .fl_addr(fl_addr), .fl_wdata(fl_wdata), .fl_dir(fl_dir), .fl_do(fl_do),
    .fl_rdata(fl_rdata), .fl_done(fl_done)
  );

  initial clk_f = 1'b0;
  always #5 clk_f = ~clk_f;

  // addr[8] set means the address of that cycle is not checked
  typedef struct { logic [8:0] addr; logic dir; logic [7:0] data; } tx_t;
  typedef struct { logic ok; logic err; logic [31:0] score; } cmp_t;
  tx_t  exp_tx[$];
  cmp_t exp_cmp[$];
  int checks, errors, done_seen, tx_seen;

  // flash model state
  logic [7:0] mem [256];
  bit         cmd_pend, status_mode, never_ready;
  logic [7:0] fail_addr, resp;
  int         pollcnt, cd, delay;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_tx(input logic [8:0] a, input logic d, input logic [7:0] v);
    tx_t t;
    t.addr = a; t.dir = d; t.data = v;
    exp_tx.push_back(t);
  endtask

  task automatic push_cmp(input logic o, input logic e, input logic [31:0] s);
    cmp_t c;
    c.ok = o; c.err = e; c.score = s;
    exp_cmp.push_back(c);
  endtask

  // fail_byte: byte whose status reports an error (-1 none); tmo: status never ready
  task automatic push_save(input logic [31:0] s, input int fail_byte, input bit tmo);
    logic [8:0] a;
    for (int b = 0; b < 4; b++) begin
      a = 9'h010 + 9'(b);
      push_tx(a, 1'b0, 8'h40);
      push_tx(a, 1'b0, s[8*b +: 8]);
      if (tmo) begin
        for (int p = 0; p < 8; p++) push_tx(a, 1'b1, 8'h00);
        push_tx(9'h100, 1'b0, 8'hFF);
        return;
      end
      push_tx(a, 1'b1, 8'h00);
      push_tx(a, 1'b1, 8'h00);
      if (b == fail_byte) begin
        push_tx(a, 1'b0, 8'h50);
        push_tx(9'h100, 1'b0, 8'hFF);
        return;
      end
    end
    push_tx(9'h100, 1'b0, 8'hFF);
  endtask

  task automatic push_load();
    push_tx(9'h010, 1'b0, 8'hFF);
    for (int b = 0; b < 4; b++) push_tx(9'h010 + 9'(b), 1'b1, 8'h00);
  endtask

  task automatic do_op(input bit sv, input bit ld, input logic [31:0] s);
    @(negedge clk_f);
    save_req = sv; load_req = ld; score_in = s;
    @(negedge clk_f);
    save_req = 1'b0; load_req = 1'b0;
  endtask

  task automatic wait_done(input int base, input string name);
    for (int c = 0; c < 600 && done_seen == base; c++) @(negedge clk_f);
    if (done_seen == base) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no completion required=completion", name);
    end
    chk({name, "_txq_empty"}, 32'(exp_tx.size()), 32'd0);
  endtask

  task automatic monitor_loop();
    tx_t  e;
    cmp_t c;
    logic fell, busy_prev;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk_f);
      fell = busy_prev && !busy && !rst;
      if (fl_do) begin
        tx_seen++;
        $display("tx addr=%h dir=%0d wdata=%h", fl_addr, fl_dir, fl_wdata);
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_fl_do actual=addr %h dir %0d data %h required=no cycle", fl_addr, fl_dir, fl_wdata);
        end else begin
          e = exp_tx.pop_front();
          if (e.dir)          chk("rd_cycle", {fl_dir, fl_addr}, {e.dir, e.addr[7:0]});
          else if (e.addr[8]) chk("wr_cycle", {fl_dir, fl_wdata}, {e.dir, e.data});
          else                chk("wr_cycle", {fl_dir, fl_addr, fl_wdata}, {e.dir, e.addr[7:0], e.data});
        end
      end
      if (fell) begin
        done_seen++;
        $display("done ok=%0d err=%0d score_out=%h", ok, err, score_out);
        if (exp_cmp.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_completion actual=ok %0d err %0d required=none", ok, err);
        end else begin
          c = exp_cmp.pop_front();
          chk("done_ok", 32'(ok), 32'(c.ok));
          chk("done_err", 32'(err), 32'(c.err));
          chk("done_score", score_out, c.score);
        end
      end else if (ok) begin
        checks++; errors++;
        $display("FAIL stray_ok actual=1 required=0");
      end
      busy_prev = busy;
    end
  endtask

  task automatic model_loop();
    forever begin
      @(negedge clk_f);
      fl_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin fl_done = 1'b1; fl_rdata = resp; end
      end
      if (fl_do) begin
        if (!fl_dir) begin
          if (cmd_pend) begin
            mem[fl_addr] = fl_wdata; cmd_pend = 1'b0; status_mode = 1'b1; pollcnt = 0;
          end else if (fl_wdata == 8'hFF) status_mode = 1'b0;
          else if (fl_wdata == 8'h40)     cmd_pend = 1'b1;
          else if (fl_wdata == 8'h50)     pollcnt = 0;
          resp = 8'h00;
        end else if (status_mode) begin
          pollcnt++;
          resp = (never_ready || pollcnt < 2) ? 8'h00 : ((fl_addr == fail_addr) ? 8'h90 : 8'h80);
        end else begin
          resp = mem[fl_addr];
        end
        cd = delay;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ok"}, 32'(ok), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_fl_do"}, 32'(fl_do), 32'd0);
    chk({tag, "_fl_dir"}, 32'(fl_dir), 32'd1);
    chk({tag, "_fl_addr"}, 32'(fl_addr), 32'd0);
    chk({tag, "_fl_wdata"}, 32'(fl_wdata), 32'd0);
    chk({tag, "_score_out"}, score_out, 32'd0);
  endtask

  initial begin
    int base;
    rst = 1'b1; save_req = 1'b0; load_req = 1'b0; score_in = '0;
    fl_rdata = '0; fl_done = 1'b0;
    checks = 0; errors = 0; done_seen = 0; tx_seen = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    cmd_pend = 1'b0; status_mode = 1'b0; never_ready = 1'b0; fail_addr = 8'hFF;
    pollcnt = 0; cd = 0; delay = 2; resp = '0;
    fork
      monitor_loop();
      model_loop();
    join_none

    repeat (3) @(negedge clk_f);
    check_reset_vals("reset");
    rst = 1'b0;

    // load of preset memory
    push_load(); push_cmp(1'b1, 1'b0, 32'h44332211);
    base = done_seen; do_op(1'b0, 1'b1, 32'h0); wait_done(base, "load1");

    // clean save, ready on the second poll
    push_save(32'hA1B2C3D4, -1, 1'b0); push_cmp(1'b1, 1'b0, 32'h44332211);
    base = done_seen; do_op(1'b1, 1'b0, 32'hA1B2C3D4); wait_done(base, "save1");

    // status 0x90 on byte 1
    fail_addr = 8'h11;
    push_save(32'hCAFEBABE, 1, 1'b0); push_cmp(1'b0, 1'b1, 32'h44332211);
    base = done_seen; do_op(1'b1, 1'b0, 32'hCAFEBABE); wait_done(base, "save_fail");
    fail_addr = 8'hFF;

    // status never ready: exactly POLL_LIMIT reads
    never_ready = 1'b1;
    push_save(32'h55667788, -1, 1'b1); push_cmp(1'b0, 1'b1, 32'h44332211);
    base = done_seen; do_op(1'b1, 1'b0, 32'h55667788);
    chk("err_cleared_on_accept", 32'(err), 32'd0);
    chk("busy_after_accept", 32'(busy), 32'd1);
    wait_done(base, "save_timeout");
    never_ready = 1'b0;

    // save and load together, then a load while busy
    push_save(32'h01020304, -1, 1'b0); push_cmp(1'b1, 1'b0, 32'h44332211);
    base = done_seen; do_op(1'b1, 1'b1, 32'h01020304);
    repeat (4) @(negedge clk_f);
    load_req = 1'b1;
    @(negedge clk_f);
    load_req = 1'b0;
    wait_done(base, "collision");

    // reset while a status poll is outstanding, late fl_done afterwards
    delay = 20;
    push_tx(9'h010, 1'b0, 8'h40); push_tx(9'h010, 1'b0, 8'h04); push_tx(9'h010, 1'b1, 8'h00);
    base = tx_seen; do_op(1'b1, 1'b0, 32'h01020304);
    for (int c = 0; c < 200 && tx_seen < base + 3; c++) @(negedge clk_f);
    chk("poll_issued_before_reset", 32'(tx_seen - base), 32'd3);
    repeat (2) @(negedge clk_f);
    rst = 1'b1;
    repeat (2) @(negedge clk_f);
    check_reset_vals("midop_reset");
    rst = 1'b0;
    repeat (30) @(negedge clk_f);
    chk("after_late_done_busy", 32'(busy), 32'd0);
    chk("after_late_done_txq", 32'(exp_tx.size()), 32'd0);
    delay = 2;

    push_load(); push_cmp(1'b1, 1'b0, 32'h01020304);
    base = done_seen; do_op(1'b0, 1'b1, 32'h0); wait_done(base, "load2");

    repeat (5) @(negedge clk_f);
    chk("cmp_queue_empty", 32'(exp_cmp.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
